// File: rtl/i2c_byte_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_byte_ctrl : byte-level I2C master sequencer (START, 8 bits, ACK, STOP).
// Optional macro I2C_CLK_STRETCH_EN enables SCL clock stretching.  Rev 1.0
// ----------------------------------------------------------------------------
module i2c_byte_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic asyn_rst,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic cmd_start,
  input  logic cmd_stop,
  input  logic cmd_read,
  input  logic cmd_nack,
  output logic done,
  output logic ack_rcvd,
  output logic busy,
  output logic sh_load,
  output logic sh_shift_en,
  output logic sh_serial_in,
  input  logic sh_serial_out,
  output logic scl_oe,
  output logic sda_oe,
  input  logic sda_in,
  input  logic scl_in
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BIT   = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4,
    HOLD  = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  logic [1:0]    phase;
  logic [2:0]    bit_cnt;
  logic          stop_l, read_l, nack_l, from_hold;
  logic          accept, active, stall, tick, phase_end, finish;

  assign accept    = cmd_valid & cmd_ready;
  assign active    = (state == START) || (state == BIT) || (state == ACK) || (state == STOP);
  assign tick      = active && !stall && (presc == PRESC_MAX);
  assign phase_end = tick && (phase == 2'd3);

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding SCL low freezes the prescaler in the SCL-high phase.
  assign stall = active && (phase == 2'd1) && !scl_in;
`else
  assign stall = 1'b0 & scl_in;
`endif

  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    sh_load     = 1'b0;
    sh_shift_en = 1'b0;
    scl_oe      = 1'b0;
    sda_oe      = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE, HOLD: begin
        cmd_ready = 1'b1;
        scl_oe    = (state == HOLD);
        if (cmd_valid) begin
          sh_load   = ~cmd_read;
          state_nxt = (cmd_start || state == IDLE) ? START : BIT;
        end
      end
      START: begin
        busy   = 1'b1;
        scl_oe = ((phase == 2'd0) && from_hold) || (phase == 2'd3);
        sda_oe = phase[1];
        if (phase_end) state_nxt = BIT;
      end
      BIT: begin
        busy        = 1'b1;
        scl_oe      = (phase == 2'd0) || (phase == 2'd3);
        sda_oe      = ~read_l & ~sh_serial_out;
        sh_shift_en = phase_end;
        if (phase_end && bit_cnt == 3'd7) state_nxt = ACK;
      end
      ACK: begin
        busy   = 1'b1;
        scl_oe = (phase == 2'd0) || (phase == 2'd3);
        sda_oe = read_l & ~nack_l;
        if (phase_end) begin
          state_nxt = stop_l ? STOP : HOLD;
          finish    = ~stop_l;
        end
      end
      STOP: begin
        busy   = 1'b1;
        scl_oe = (phase == 2'd0);
        sda_oe = ~phase[1];
        if (phase_end) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      presc        <= '0;
      phase        <= 2'd0;
      bit_cnt      <= 3'd0;
      stop_l       <= 1'b0;
      read_l       <= 1'b0;
      nack_l       <= 1'b0;
      from_hold    <= 1'b0;
      sh_serial_in <= 1'b0;
      done         <= 1'b0;
      ack_rcvd     <= 1'b0;
    end else begin
      done <= finish;
      if (finish) ack_rcvd <= ~read_l & ~sh_serial_in;
      if (accept) begin
        presc     <= '0;
        phase     <= 2'd0;
        bit_cnt   <= 3'd0;
        stop_l    <= cmd_stop;
        read_l    <= cmd_read;
        nack_l    <= cmd_nack;
        from_hold <= (state == HOLD);
      end else if (tick) begin
        // Phase wrap at the end of p3 doubles as the reload on state entry.
        presc <= '0;
        phase <= phase + 2'd1;
        if (state == BIT && phase == 2'd3) bit_cnt <= bit_cnt + 3'd1;
        if (phase == 2'd1 && (state == BIT || state == ACK)) sh_serial_in <= sda_in;
      end else if (active && !stall) begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_ctrl.sv
`default_nettype none
// tb_i2c_byte_ctrl : scoreboard bench for i2c_byte_ctrl with shift-register
// and I2C slave stubs; expected results are queued at issue, checked on done.
module tb_i2c_byte_ctrl;
  localparam int CLK_DIV = 2;
`ifdef I2C_CLK_STRETCH_EN
  localparam int STRETCH_DLY = 20;
`else
  localparam int STRETCH_DLY = 0;
`endif

  logic clk = 1'b0;
  logic asyn_rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_start = 1'b0, cmd_stop = 1'b0, cmd_read = 1'b0, cmd_nack = 1'b0;
  logic cmd_ready, done, ack_rcvd, busy, sh_load, sh_shift_en, sh_serial_in, sh_serial_out;
  logic scl_oe, sda_oe, sda_in, scl_in, scl_line;
  logic [7:0] data_in = 8'h00;
  logic [7:0] sr = 8'h00;
  logic hold_low = 1'b0, slave_pull = 1'b0, stretch_arm = 1'b0;

  always #5 clk = ~clk;

  i2c_byte_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .asyn_rst(asyn_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_read(cmd_read), .cmd_nack(cmd_nack),
    .done(done), .ack_rcvd(ack_rcvd), .busy(busy), .sh_load(sh_load),
    .sh_shift_en(sh_shift_en), .sh_serial_in(sh_serial_in), .sh_serial_out(sh_serial_out),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in), .scl_in(scl_in)
  );

  // Open-drain bus and external byte shift register.
  assign scl_in        = !(scl_oe | hold_low);
  assign sda_in        = !(sda_oe | slave_pull);
  assign sh_serial_out = sr[7];
`ifdef I2C_CLK_STRETCH_EN
  assign scl_line = scl_in;
`else
  assign scl_line = !scl_oe;
`endif

  always @(posedge clk) begin
    if (sh_load)          sr <= data_in;
    else if (sh_shift_en) sr <= {sr[6:0], sh_serial_in};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cycles;
    logic       chk_ack;
    logic       ack;
    logic [7:0] data;
    logic       stop;
    logic       ack_oe;
    int         loads;
  } exp_t;
  exp_t sb[$];
  exp_t got;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave / bus monitor state.
  int bitpos = 9;
  logic prev_scl = 1'b1, prev_sda = 1'b1;
  logic slv_read = 1'b0, slv_ack = 1'b0;
  logic [7:0] slv_byte = 8'h00;
  int t_acc = 0, n_load = 0, n_shift = 0, n_start = 0, n_stop = 0;
  logic [7:0] bus_byte = 8'h00;
  logic ack_oe = 1'b0, ready_busy = 1'b0;

  always @(negedge clk) begin
    if (cmd_valid && cmd_ready && !asyn_rst) begin
      t_acc = cyc + 1; n_load = 0; n_shift = 0; n_start = 0; n_stop = 0; ready_busy = 1'b0;
    end
    if (sh_load) n_load++;
    if (sh_shift_en) n_shift++;
    if (busy && cmd_ready) ready_busy = 1'b1;

    if (prev_scl && scl_line && prev_sda && !sda_in) begin
      n_start++; bitpos = -1;
    end else if (prev_scl && scl_line && !prev_sda && sda_in) begin
      n_stop++; bitpos = 9;
    end else if (!prev_scl && scl_line) begin
      if (bitpos >= 0 && bitpos < 8) bus_byte = {bus_byte[6:0], sda_in};
      else if (bitpos == 8) ack_oe = sda_oe;
    end else if (prev_scl && !scl_line && bitpos < 9) begin
      bitpos++;
    end

    if (slv_read) slave_pull = (bitpos >= 0 && bitpos < 8) ? !slv_byte[3'(7 - bitpos)] : 1'b0;
    else          slave_pull = (bitpos == 8) && slv_ack;
    prev_scl = scl_line;
    prev_sda = !(sda_oe | slave_pull);

    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(sb.size()), 32'd1);
      end else begin
        got = sb.pop_front();
        chk("done_latency", 32'(cyc - t_acc), 32'(got.cycles));
        if (got.chk_ack) chk("ack_rcvd", 32'(ack_rcvd), 32'(got.ack));
        chk("data_out", 32'(sr), 32'(got.data));
        chk("bus_byte", 32'(bus_byte), 32'(got.data));
        chk("ack_bit_sda_oe", 32'(ack_oe), 32'(got.ack_oe));
        chk("sh_load_pulses", 32'(n_load), 32'(got.loads));
        chk("sh_shift_pulses", 32'(n_shift), 32'd8);
        chk("start_conds", 32'(n_start), 32'd1);
        chk("stop_conds", 32'(n_stop), 32'(got.stop));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("ready_at_done", 32'(cmd_ready), 32'd1);
        chk("ready_while_busy", 32'(ready_busy), 32'd0);
        chk("scl_oe_at_done", 32'(scl_oe), 32'(!got.stop));
        chk("sda_oe_at_done", 32'(sda_oe), 32'd0);
      end
    end
  end

  // Holds SCL low for 20 clocks once SCL is released in bit 2.
  initial forever begin
    @(posedge clk); #1;
    if (stretch_arm && bitpos == 2 && !scl_oe) begin
      stretch_arm = 1'b0;
      hold_low    = 1'b1;
      repeat (20) @(posedge clk);
      #1 hold_low = 1'b0;
    end
  end

  task automatic issue(input logic st, input logic sp, input logic rd, input logic nk,
                       input logic [7:0] byt, input logic ack, input int extra);
    exp_t e;
    slv_read = rd; slv_byte = byt; slv_ack = ack;
    e.cycles  = ((st ? 1 : 0) + 9 + (sp ? 1 : 0)) * 4 * CLK_DIV + extra;
    e.chk_ack = !rd;
    e.ack     = ack;
    e.data    = byt;
    e.stop    = sp;
    e.ack_oe  = rd & !nk;
    e.loads   = rd ? 0 : 1;
    sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_start = st; cmd_stop = sp; cmd_read = rd; cmd_nack = nk;
    data_in = rd ? 8'h00 : byt;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_read = 1'b0; cmd_nack = 1'b0;
    data_in = 8'h00;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("done_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    logic found;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ack_rcvd", 32'(ack_rcvd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sh_load", 32'(sh_load), 32'd0);
    chk("rst_sh_shift_en", 32'(sh_shift_en), 32'd0);
    chk("rst_sh_serial_in", 32'(sh_serial_in), 32'd0);
    chk("rst_scl_oe", 32'(scl_oe), 32'd0);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    asyn_rst = 1'b0;
    repeat (2) @(posedge clk);

    issue(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 0);     // write with slave ACK
    wait_done();
    issue(1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 0);     // read, NACK, stop
    wait_done();

    issue(1'b1, 1'b0, 1'b0, 1'b0, 8'h96, 1'b1, 0);     // write, park in HOLD
    wait_done();
    repeat (5) @(posedge clk);
    #1;
    chk("hold_scl_oe", 32'(scl_oe), 32'd1);
    chk("hold_sda_oe", 32'(sda_oe), 32'd0);
    chk("hold_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("hold_busy", 32'(busy), 32'd0);
    issue(1'b1, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 0);     // repeated START read, ACK
    wait_done();

    issue(1'b1, 1'b1, 1'b0, 1'b0, 8'h3F, 1'b0, 0);     // write, no slave
    wait_done();

    issue(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 0);     // reset during bit 4
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk); #1;
      if (bitpos == 4 && !scl_oe) found = 1'b1;
    end
    chk("reach_bit4", 32'(found), 32'd1);
    asyn_rst = 1'b1;
    #1;
    chk("midrst_scl_oe", 32'(scl_oe), 32'd0);
    chk("midrst_sda_oe", 32'(sda_oe), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    sb.delete();
    @(posedge clk); #1;
    asyn_rst = 1'b0;
    repeat (2) @(posedge clk);
    issue(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 0);
    wait_done();

    stretch_arm = 1'b1;                                 // stretch bit 2
    issue(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, STRETCH_DLY);
    wait_done();
    chk("stretch_consumed", 32'(stretch_arm), 32'd0);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
